// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - shared ISA constants: opcodes, field positions, formats, loader error codes
package cpu_isa_pkg;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_ADDI  = 4'h3;
  localparam logic [3:0] OP_SUBI  = 4'h4;
  localparam logic [3:0] OP_LSH   = 4'h5;
  localparam logic [3:0] OP_RSH   = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_JUMPL = 4'h8;
  localparam logic [3:0] OP_BGE   = 4'h9;
  localparam logic [3:0] OP_BLE   = 4'hA;
  localparam logic [3:0] OP_BNE   = 4'hB;
  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_AND   = 4'hE;
  localparam logic [3:0] OP_OR    = 4'hF;

  // Field bit positions inside the 16-bit instruction word
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int FA_LSB = 8;   // rd / rs2 (store) / rs1 (branch)
  localparam int FB_LSB = 4;   // rs1 / rs2 (branch)
  localparam int FC_LSB = 0;   // rs2 / imm[3:0]

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_H} instr_fmt_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_IMM  = 2'd1;
  localparam logic [1:0] ERR_FULL = 2'd2;
  localparam logic [1:0] ERR_JUMP = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} loader_state_t;

  function automatic instr_fmt_t op_format(input logic [3:0] op);
    case (op)
      OP_HALT:                    return FMT_H;
      OP_ADDI, OP_SUBI, OP_LOAD:  return FMT_I;
      OP_STORE:                   return FMT_S;
      OP_BGE, OP_BLE, OP_BNE:     return FMT_B;
      OP_JUMP, OP_JUMPL:          return FMT_J;
      default:                    return FMT_R;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packer and range checker for one symbolic instruction
module instr_pack
  import cpu_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [11:0] imm,
  input  logic [12:0] jump_limit,
  output logic [15:0] word,
  output logic        valid,
  output logic [1:0]  err_code
);

  // A 4-bit signed field holds -8..7: the upper nine bits must be pure sign extension
  logic imm_fits;
  logic target_fits;
  assign imm_fits    = (imm[11:3] == 9'h000) || (imm[11:3] == 9'h1FF);
  assign target_fits = {1'b0, imm} < jump_limit;

  // Select the field layout by format and flag out-of-range immediates
  always_comb begin
    word     = 16'h0000;
    valid    = 1'b1;
    err_code = ERR_NONE;
    case (op_format(op))
      FMT_R: word = {op, rd, rs1, rs2};
      FMT_I: begin
        word = {op, rd, rs1, imm[3:0]};
        if (!imm_fits) begin
          valid    = 1'b0;
          err_code = ERR_IMM;
        end
      end
      FMT_S: begin
        word = {op, rs2, rs1, imm[3:0]};
        if (!imm_fits) begin
          valid    = 1'b0;
          err_code = ERR_IMM;
        end
      end
      FMT_B: begin
        word = {op, rs1, rs2, imm[3:0]};
        if (!imm_fits) begin
          valid    = 1'b0;
          err_code = ERR_IMM;
        end
      end
      FMT_J: begin
        word = {op, imm};
        if (!target_fits) begin
          valid    = 1'b0;
          err_code = ERR_JUMP;
        end
      end
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - sequential instruction memory writer; LOADER_CHECKSUM_EN adds a running checksum output
module program_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  // Jump targets must address imem; beyond 12 address bits every target fits
  localparam logic [12:0] JUMP_LIMIT = (ADDR_W >= 12) ? 13'h1000 : 13'(1 << ADDR_W);

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] next_addr;
  logic [15:0]       pack_word;
  logic              pack_ok;
  logic [1:0]        pack_err;
  logic              accept;
  logic              at_last;
  logic              session_start;

  instr_pack u_pack (
    .op         (in_op),
    .rd         (in_rd),
    .rs1        (in_rs1),
    .rs2        (in_rs2),
    .imm        (in_imm),
    .jump_limit (JUMP_LIMIT),
    .word       (pack_word),
    .valid      (pack_ok),
    .err_code   (pack_err)
  );

  assign accept        = in_valid && in_ready;
  assign at_last       = (next_addr == {ADDR_W{1'b1}});
  assign session_start = start && (state != ST_LOAD);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: stop on HALT, on a rejected instruction, or after filling the last slot
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          if (!pack_ok)             state_nxt = ST_ERR;
          else if (in_op == OP_HALT) state_nxt = ST_DONE;
          else if (at_last)          state_nxt = ST_ERR;
        end
      end
      default: if (start) state_nxt = ST_LOAD;
    endcase
  end

  // Handshake outputs depend on state only
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state == ST_LOAD) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // Address counter, write port and sticky status; a session start clears the status
  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      imem_we <= 1'b0;
      if (session_start) begin
        next_addr  <= start_addr;
        word_count <= '0;
        done       <= 1'b0;
        error      <= 1'b0;
        err_code   <= ERR_NONE;
      end else if (accept) begin
        if (pack_ok) begin
          imem_we    <= 1'b1;
          imem_addr  <= next_addr;
          imem_wdata <= INSTR_W'(pack_word);
          word_count <= word_count + 1'b1;
          // Saturate at the last slot; the session ends there anyway
          if (!at_last) next_addr <= next_addr + 1'b1;
          if (in_op == OP_HALT) begin
            done <= 1'b1;
          end else if (at_last) begin
            error    <= 1'b1;
            err_code <= ERR_FULL;
          end
        end else begin
          error    <= 1'b1;
          err_code <= pack_err;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running checksum over written words, updated the cycle after each write
  always_ff @(posedge clk) begin
    if (rst || session_start) checksum <= 16'h0000;
    else if (imem_we)         checksum <= {checksum[14:0], checksum[15]} ^ imem_wdata[15:0];
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader with randomized stimulus; LOADER_CHECKSUM_EN checks checksum
module tb_program_loader;

  localparam int AW = 8;
  localparam int LAST = (1 << AW) - 1;

  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [AW-1:0] start_addr = '0;
  logic [3:0] in_op = 0, in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [11:0] in_imm = 0;
  logic in_ready, imem_we, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [1:0] err_code;
  logic [AW:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  program_loader #(.ADDR_W(AW), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .word_count(word_count)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [23:0] exp_q[$];
  logic [AW-1:0] last_addr = '0;
  logic [15:0] last_data = '0;

  // Reference model: 0 idle, 1 loading, 2 done, 3 error
  int m_state = 0, m_addr = 0, m_cnt = 0, m_done = 0, m_err = 0, m_code = 0;
  logic [15:0] m_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Encoding straight from the format table, using integer arithmetic
  function automatic void ref_encode(input int op, input int rd, input int rs1, input int rs2,
                                     input logic [11:0] imm, output int word, output int code);
    int simm, uimm, lo;
    simm = $signed(imm);
    uimm = int'(imm);
    lo   = uimm % 16;
    code = 0;
    word = 0;
    case (op)
      0: word = 0;
      3, 4, 12: begin
        word = op * 4096 + rd * 256 + rs1 * 16 + lo;
        if (simm < -8 || simm > 7) code = 1;
      end
      13: begin
        word = op * 4096 + rs2 * 256 + rs1 * 16 + lo;
        if (simm < -8 || simm > 7) code = 1;
      end
      9, 10, 11: begin
        word = op * 4096 + rs1 * 256 + rs2 * 16 + lo;
        if (simm < -8 || simm > 7) code = 1;
      end
      7, 8: begin
        word = op * 4096 + uimm;
        if (uimm >= (1 << AW)) code = 3;
      end
      default: word = op * 4096 + rd * 256 + rs1 * 16 + rs2;
    endcase
  endfunction

  // Monitor: every write the DUT presents must match the head of the expected queue
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_bad++;
          $display("FAIL write: got %0h@%0h expected %0h@%0h", imem_wdata, imem_addr, e[15:0], e[23:16]);
        end
      end
      last_addr = imem_addr;
      last_data = imem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic do_start(input int addr, input bit with_valid);
    start = 1;
    start_addr = AW'(addr);
    in_valid = with_valid;
    in_op = 4'h1;
    @(posedge clk); #1;
    start = 0;
    in_valid = 0;
    if (m_state != 1) begin
      m_state = 1; m_addr = addr; m_cnt = 0; m_done = 0; m_err = 0; m_code = 0; m_chk = 0;
    end
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input logic [11:0] imm);
    int word, code;
    bit acc;
    in_valid = 1;
    in_op = 4'(op); in_rd = 4'(rd); in_rs1 = 4'(rs1); in_rs2 = 4'(rs2); in_imm = imm;
    chk("in_ready", 32'(in_ready), 32'(m_state == 1));
    acc = (m_state == 1);
    @(posedge clk); #1;
    in_valid = 0;
    if (acc) begin
      ref_encode(op, rd, rs1, rs2, imm, word, code);
      if (code != 0) begin
        m_state = 3; m_err = 1; m_code = code;
      end else begin
        exp_q.push_back({8'(m_addr), 16'(word)});
        m_chk = {m_chk[14:0], m_chk[15]} ^ 16'(word);
        m_cnt++;
        if (op == 0) begin
          m_state = 2; m_done = 1;
        end else if (m_addr == LAST) begin
          m_state = 3; m_err = 1; m_code = 2;
        end else begin
          m_addr++;
        end
      end
    end
  endtask

  task automatic check_status(input string tag);
    @(posedge clk); #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_state == 1));
    chk({tag, ".busy"}, 32'(busy), 32'(m_state == 1));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".error"}, 32'(error), 32'(m_err));
    chk({tag, ".err_code"}, 32'(err_code), 32'(m_code));
    chk({tag, ".word_count"}, 32'(word_count), 32'(m_cnt));
`ifdef LOADER_CHECKSUM_EN
    chk({tag, ".checksum"}, 32'(checksum), 32'(m_chk));
`endif
  endtask

  task automatic expect_last(input string tag, input int addr, input int data);
    @(posedge clk); #1;
    chk({tag, ".addr"}, 32'(last_addr), 32'(addr));
    chk({tag, ".data"}, 32'(last_data), 32'(data));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".imem_we"}, 32'(imem_we), 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".error"}, 32'(error), 0);
    chk({tag, ".err_code"}, 32'(err_code), 0);
    chk({tag, ".word_count"}, 32'(word_count), 0);
    chk({tag, ".imem_addr"}, 32'(imem_addr), 0);
    chk({tag, ".imem_wdata"}, 32'(imem_wdata), 0);
  endtask

  task automatic do_reset_mid();
    rst = 1;
    in_valid = 1; in_op = 4'h1; in_rd = 4'h2; in_rs1 = 4'h3; in_rs2 = 4'h4;
    @(posedge clk); #1;
    rst = 0;
    in_valid = 0;
    check_reset_outputs("rst_mid");
    m_state = 0; m_addr = 0; m_cnt = 0; m_done = 0; m_err = 0; m_code = 0; m_chk = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_reset_outputs("reset");

    // in_valid while idle is ignored
    send(1, 1, 2, 3, 12'h0);
    check_status("idle_valid");

    // start with in_valid in the same cycle; ADDI then HALT
    do_start(16'h10, 1'b1);
    send(3, 1, 0, 0, 12'd5);
    expect_last("addi", 16'h10, 16'h3105);
    send(0, 0, 0, 0, 12'h0);
    expect_last("halt", 16'h11, 16'h0000);
    check_status("halt");
    chk("halt.done_const", 32'(done), 1);
    chk("halt.count_const", 32'(word_count), 2);

    // Format vectors; a start during LOAD is ignored
    do_start(16'h40, 1'b0);
    send(11, 0, 2, 3, 12'hFFE);
    expect_last("bne", 16'h40, 16'hB23E);
    do_start(16'h80, 1'b0);
    send(13, 0, 5, 4, 12'd1);
    expect_last("store", 16'h41, 16'hD451);
    send(8, 0, 0, 0, 12'h0A3);
    expect_last("jumpl", 16'h42, 16'h80A3);
    send(0, 0, 0, 0, 12'h0);
    check_status("fmt");

    // Immediate out of range, then restart
    do_start(16'h20, 1'b0);
    send(3, 1, 0, 0, 12'd8);
    check_status("imm_err");
    send(1, 1, 1, 1, 12'h0);
    do_start(16'h20, 1'b0);
    check_status("imm_restart");
    send(1, 1, 2, 3, 12'h0);
    send(0, 0, 0, 0, 12'h0);
    check_status("resume");

    // Jump target out of range
    do_start(16'h30, 1'b0);
    send(7, 0, 0, 0, 12'h100);
    check_status("jump_err");

    // Memory full, and HALT at the last slot
    do_start(16'hFE, 1'b0);
    send(1, 1, 2, 3, 12'h0);
    send(1, 4, 5, 6, 12'h0);
    send(1, 7, 8, 9, 12'h0);
    check_status("full");
    chk("full.code_const", 32'(err_code), 2);
    do_start(16'hFE, 1'b0);
    send(1, 1, 2, 3, 12'h0);
    send(0, 0, 0, 0, 12'h0);
    check_status("halt_last");

    // Checksum vector 0x1123, 0x0000
    do_start(16'h00, 1'b0);
    send(1, 1, 2, 3, 12'h0);
    send(0, 0, 0, 0, 12'h0);
    check_status("cksum");
`ifdef LOADER_CHECKSUM_EN
    chk("cksum.const", 32'(checksum), 32'h2246);
`endif

    // Randomized sessions with idle gaps and one mid-session reset
    for (int s = 0; s < 10; s++) begin
      do_start(($urandom_range(0, 2) == 0) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 200)), 1'b0);
      for (int k = 0; k < 40 && m_state == 1; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end else begin
          int op, v;
          logic [11:0] imm;
          op = ($urandom_range(0, 29) == 0) ? 0 : int'($urandom_range(1, 15));
          case ($urandom_range(0, 9))
            0: imm = 12'($urandom);
            1: imm = 12'd8;
            2: imm = 12'hFF7;
            3: imm = 12'($urandom_range(0, 255));
            default: begin
              v = int'($urandom_range(0, 15)) - 8;
              imm = 12'(v);
            end
          endcase
          send(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), imm);
        end
        if (s == 6 && k == 5 && m_state == 1) do_reset_mid();
      end
      check_status("rand");
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction stream that the control unit decodes.
- Accepts symbolic instructions (opcode plus register and immediate fields) over a valid/ready handshake.
- Packs each one into a 16-bit instruction word, range-checks its fields, and writes it sequentially into instruction memory from a programmable start address.
- Used by the testbench and the boot path to load programs ahead of CPU execution. Stops on HALT, on error, or when memory is full.

Parameters:
- ADDR_W, 8, instruction memory address width; depth is 2^ADDR_W words.
- INSTR_W, 16, instruction word width; fixed at 16, present for port sizing only.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load session
- start_addr  in  ADDR_W  first imem address of the session
- in_valid  in  1  instruction fields valid
- in_ready  out  1  loader can accept an instruction this cycle
- in_op  in  4  opcode (0 HALT, 1 ADD, 2 SUB, 3 ADDI, 4 SUBI, 5 LSH, 6 RSH, 7 JUMP, 8 JUMPL, 9 BGE, A BLE, B BNE, C LOAD, D STORE, E AND, F OR)
- in_rd  in  4  destination register
- in_rs1  in  4  source 1 / base register
- in_rs2  in  4  source 2 / store-data register
- in_imm  in  12  signed immediate / branch offset, or unsigned jump target
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  encoded instruction
- busy  out  1  session in progress
- done  out  1  HALT written; sticky
- error  out  1  session aborted; sticky
- err_code  out  2  error cause: 0 none, 1 immediate out of range, 2 memory full, 3 jump target out of range
- word_count  out  ADDR_W+1  words written this session

Behaviour:
- Reset
  - State IDLE.
  - in_ready, imem_we, busy, done and error are 0.
  - imem_addr, imem_wdata, err_code and word_count are 0.
- Encoding (bits [15:12] always hold the opcode)
  - R-type (ADD, SUB, LSH, RSH, AND, OR): rd[11:8], rs1[7:4], rs2[3:0].
  - I-type (ADDI, SUBI, LOAD): rd[11:8], rs1[7:4], imm[3:0].
  - STORE: rs2[11:8], rs1[7:4], imm[3:0].
  - Branch (BGE, BLE, BNE): rs1[11:8], rs2[7:4], offset[3:0].
  - JUMP, JUMPL: target[11:0].
  - HALT: 0x0000.
- Range checks
  - I-type, STORE and branch: in_imm must lie in -8..+7 (signed). Otherwise error 1.
  - JUMP/JUMPL: in_imm, read as unsigned, must be < 2^ADDR_W. Otherwise error 3.
  - Unused fields are ignored.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE → LOAD on start. Latch the next address from start_addr; clear word_count, done, error and err_code.
  - LOAD: in_ready=1 and busy=1.
    - A transfer occurs when in_valid && in_ready.
    - Valid transfer: on the next edge, imem_we=1 for exactly one cycle, imem_addr = current next-address, and imem_wdata = the encoded word (1-cycle latency). The next address increments and word_count increments.
    - Invalid transfer: no write. Go to ERR and set err_code.
  - LOAD → DONE after a HALT is accepted; its write still occurs.
  - LOAD → ERR with code 2 when a non-HALT instruction is accepted while the next address equals 2^ADDR_W-1. That word is still written (last slot) and the loader then stops.
    - A HALT accepted at the last slot goes to DONE, not ERR.
    - The address never wraps.
  - DONE/ERR: in_ready=0. Hold the sticky flags. A start pulse re-enters LOAD as from IDLE.
- Other boundary cases
  - start while in LOAD is ignored.
  - in_valid outside LOAD is ignored.
  - in_valid and start in the same cycle in IDLE: only start is taken.
- rst mid-session: returns to IDLE at the next edge. A write registered in the same cycle is discarded; imem_we=0 after reset.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[15:0], cleared at start and at reset.
  - On every imem write it updates to (checksum rotated left 1) XOR imem_wdata, visible the cycle after the write.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (`cpu_isa_pkg`):
  - Opcode constants OP_HALT..OP_OR.
  - Field bit positions.
  - Instruction format enum (R, I, S, B, J, H).
  - err_code constants.
  - This package is shared with the control unit and decode logic.
- One combinational sub-module, `instr_pack`:
  - Inputs: op, rd, rs1, rs2, imm, and the addr-width limit.
  - Outputs: 16-bit word, valid flag, err_code.
- The FSM, address counter and output registers stay in `program_loader`.

Test Plan:
- start, start_addr=0x10; send ADDI rd=1 rs1=0 imm=5, then HALT → writes 0x3105@0x10 and 0x0000@0x11; done=1; word_count=2; in_ready=0 afterwards.
- BNE rs1=2 rs2=3 offset=-2 → 0xB23E; STORE rs2=4 rs1=5 imm=1 → 0xD451; JUMPL target=0x0A3 → 0x80A3.
- ADDI imm=8 → no write; error=1, err_code=1; state ERR; next start clears it and a load resumes.
- ADDR_W=8, start_addr=0xFE; ADD, ADD → writes @0xFE and @0xFF, then err_code=2; a third in_valid is refused (in_ready=0). Repeat with the second instruction as HALT → done=1, no error.
- in_valid toggled randomly with backpressure-free acceptance; assert rst mid-stream → next cycle IDLE, all outputs at reset values, no spurious imem_we.
- With LOADER_CHECKSUM_EN: words 0x1123, 0x0000 → checksum 0x1123 then 0x2246.
